// File: rtl/hnoc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// hnoc_rr_arbiter
//
// Round-robin output-port arbiter for the hierarchical NoC switch. Shares one
// outgoing link among NumIn incoming flit streams. Flits ({addr, data}) pass
// through unmodified behind a single registered output stage.
//
// Ports:
//   i_clk        clock, all state on the rising edge
//   i_reset      asynchronous active-high reset
//   i_in_data    flattened input flits, input k at [k*TotalWidth +: TotalWidth]
//   i_in_valid   per-input valid
//   o_in_ready   per-input ready, at most one bit set
//   o_out_data   registered output flit
//   o_out_valid  output flit valid
//   i_out_ready  downstream ready
//   o_grant      one-hot source of the held flit, zero when not valid
//   o_pkt_count  number of completed output handshakes (wraps)
// -----------------------------------------------------------------------------
module hnoc_rr_arbiter #(
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = 4,
    parameter int NumIn      = 4,
    localparam int TotalWidth = DataWidth + AddrWidth,
    localparam int PtrWidth   = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [NumIn*TotalWidth-1:0] i_in_data,
    input  logic [NumIn-1:0]            i_in_valid,
    output logic [NumIn-1:0]            o_in_ready,
    output logic [TotalWidth-1:0]       o_out_data,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [NumIn-1:0]            o_grant,
    output logic [31:0]                 o_pkt_count
);

    localparam logic [PtrWidth:0]  NumInW  = NumIn;
    localparam logic [NumIn-1:0]   OneHot0 = 1;

    logic [PtrWidth-1:0]   rr_ptr_reg;
    logic [TotalWidth-1:0] out_data_reg;
    logic                  out_valid_reg;
    logic [NumIn-1:0]      grant_reg;
    logic [31:0]           pkt_count_reg;

    logic [TotalWidth-1:0] in_word    [NumIn];
    logic [PtrWidth-1:0]   cand_idx   [NumIn];
    logic [NumIn-1:0]      cand_valid;

    logic                  load_en;
    logic                  win_found;
    logic [PtrWidth-1:0]   win_idx;
    logic [NumIn-1:0]      win_onehot;
    logic [PtrWidth-1:0]   ptr_next;
    logic                  accept;

    // Unpack the flattened input bus and build the rotated candidate list:
    // candidate gi is input (rr_ptr + gi) mod NumIn, so candidate 0 has the
    // highest priority.
    genvar gi;
    generate
        for (gi = 0; gi < NumIn; gi++) begin : g_cand
            localparam logic [PtrWidth:0] Off = gi;
            logic [PtrWidth:0] cand_sum;
            logic [PtrWidth:0] cand_wrap;

            assign in_word[gi]   = i_in_data[gi*TotalWidth +: TotalWidth];
            assign cand_sum      = {1'b0, rr_ptr_reg} + Off;
            assign cand_wrap     = (cand_sum >= NumInW) ? (cand_sum - NumInW) : cand_sum;
            assign cand_idx[gi]  = cand_wrap[PtrWidth-1:0];
            assign cand_valid[gi] = i_in_valid[cand_idx[gi]];
        end
    endgenerate

    // Scan from lowest priority to highest so the highest-priority valid
    // candidate is the last one written.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NumIn - 1; i >= 0; i--) begin
            if (cand_valid[i]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[i];
            end
        end
    end

    // Pointer moves just past the winner, not merely by one.
    logic [PtrWidth:0] ptr_sum;
    assign ptr_sum  = {1'b0, win_idx} + 1'b1;
    assign ptr_next = (ptr_sum >= NumInW) ? '0 : ptr_sum[PtrWidth-1:0];

    assign load_en    = !out_valid_reg || i_out_ready;
    assign accept     = win_found && load_en;
    assign win_onehot = OneHot0 << win_idx;

    // Reset gates ready low so nothing upstream sees an accept during reset.
    assign o_in_ready = (accept && !i_reset) ? win_onehot : '0;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rr_ptr_reg    <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            grant_reg     <= '0;
            pkt_count_reg <= '0;
        end else begin
            if (load_en) begin
                if (win_found) begin
                    out_data_reg  <= in_word[win_idx];
                    out_valid_reg <= 1'b1;
                    grant_reg     <= win_onehot;
                    rr_ptr_reg    <= ptr_next;
                end else begin
                    // Data is left as-is; it is don't-care while not valid.
                    out_valid_reg <= 1'b0;
                    grant_reg     <= '0;
                end
            end
            if (out_valid_reg && i_out_ready) begin
                pkt_count_reg <= pkt_count_reg + 32'd1;
            end
        end
    end

    assign o_out_data  = out_data_reg;
    assign o_out_valid = out_valid_reg;
    assign o_grant     = grant_reg;
    assign o_pkt_count = pkt_count_reg;

endmodule

// File: tb/tb_hnoc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hnoc_rr_arbiter
//
// Directed bench for hnoc_rr_arbiter (default parameters: 4 inputs, 36-bit
// flits). Inputs are driven after the falling edge; combinational ready is
// sampled 1 time unit later, registered outputs 1 time unit after the rising
// edge. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_hnoc_rr_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NI    = 4;
    localparam int TW    = DW + AW;

    logic                 clk;
    logic                 rst;
    logic [NI*TW-1:0]     in_data;
    logic [NI-1:0]        in_valid;
    logic [NI-1:0]        in_ready;
    logic [TW-1:0]        out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [NI-1:0]        grant;
    logic [31:0]          pkt_count;

    logic [TW-1:0]        in_flit [NI];

    int checks_total;
    int checks_passed;

    hnoc_rr_arbiter #(
        .DataWidth (DW),
        .AddrWidth (AW),
        .NumIn     (NI)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_in_data   (in_data),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_grant     (grant),
        .o_pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int k = 0; k < NI; k++) begin
            in_data[k*TW +: TW] = in_flit[k];
        end
    end

    function automatic logic [TW-1:0] flit(input int a, input int d);
        logic [AW-1:0] av;
        logic [DW-1:0] dv;
        av = AW'(a);
        dv = DW'(d);
        return {av, dv};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic to_negedge();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " valid"}, 64'(out_valid), 64'd0);
        check({tag, " data"},  64'(out_data),  64'd0);
        check({tag, " grant"}, 64'(grant),     64'd0);
        check({tag, " count"}, 64'(pkt_count), 64'd0);
        check({tag, " ready"}, 64'(in_ready),  64'd0);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        for (int k = 0; k < NI; k++) in_flit[k] = '0;

        // ---------------- reset state ----------------
        #2;
        check_zero_outputs("reset");
        to_negedge();
        rst = 1'b0;

        // ---------------- single requester on input 2 ----------------
        out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            to_negedge();
            in_flit[2] = flit(2, 'h10 + j);
            in_valid   = 4'b0100;
            #1;
            check($sformatf("single ready %0d", j), 64'(in_ready), 64'h4);
            tick();
            check($sformatf("single valid %0d", j), 64'(out_valid), 64'd1);
            check($sformatf("single data %0d", j),  64'(out_data), 64'(flit(2, 'h10 + j)));
            check($sformatf("single grant %0d", j), 64'(grant), 64'h4);
            $display("single   flit %0d data=%h grant=%b count=%0d", j, out_data, grant, pkt_count);
        end
        to_negedge();
        in_valid = '0;
        tick();
        check("single count", 64'(pkt_count), 64'd10);
        check("single drained", 64'(out_valid), 64'd0);

        // ---------------- reset mid-operation with a flit held ----------------
        to_negedge();
        out_ready  = 1'b0;
        in_flit[1] = flit(1, 'h55);
        in_valid   = 4'b0010;
        tick();
        check("hold valid", 64'(out_valid), 64'd1);
        to_negedge();
        in_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        $display("midrst   valid=%b data=%h grant=%b count=%0d", out_valid, out_data, grant, pkt_count);
        #1;
        rst = 1'b0;
        in_flit[1] = flit(1, 'h61);
        in_flit[3] = flit(3, 'h63);
        in_valid   = 4'b1010;
        out_ready  = 1'b1;
        tick();
        check("post-rst grant", 64'(grant), 64'h2);
        check("post-rst data",  64'(out_data), 64'(flit(1, 'h61)));
        check("post-rst count", 64'(pkt_count), 64'd0);
        $display("postrst  data=%h grant=%b", out_data, grant);

        // ---------------- full contention ----------------
        to_negedge();
        in_valid = '0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int k = 0; k < NI; k++) in_flit[k] = flit(k, 'hA0 + k);
        in_valid = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            if (j > 0) to_negedge();
            #1;
            check($sformatf("cont ready %0d", j), 64'(in_ready), 64'(4'b0001 << (j % 4)));
            tick();
            check($sformatf("cont grant %0d", j), 64'(grant), 64'(4'b0001 << (j % 4)));
            check($sformatf("cont data %0d", j),  64'(out_data), 64'(flit(j % 4, 'hA0 + (j % 4))));
            $display("contend  cycle %0d grant=%b data=%h count=%0d", j, grant, out_data, pkt_count);
        end
        check("cont count", 64'(pkt_count), 64'd7);

        // ---------------- backpressure, input 3 held ----------------
        for (int j = 0; j < 5; j++) begin
            to_negedge();
            out_ready = 1'b0;
            #1;
            check($sformatf("bp ready %0d", j), 64'(in_ready), 64'd0);
            tick();
            check($sformatf("bp data %0d", j),  64'(out_data), 64'(flit(3, 'hA3)));
            check($sformatf("bp grant %0d", j), 64'(grant), 64'h8);
            check($sformatf("bp count %0d", j), 64'(pkt_count), 64'd7);
            $display("stall    cycle %0d grant=%b count=%0d", j, grant, pkt_count);
        end
        to_negedge();
        out_ready = 1'b1;
        #1;
        check("bp release ready", 64'(in_ready), 64'h1);
        tick();
        check("bp release count", 64'(pkt_count), 64'd8);
        check("bp release grant", 64'(grant), 64'h1);
        check("bp release data",  64'(out_data), 64'(flit(0, 'hA0)));

        // ---------------- pointer skip (rr_ptr = 1, inputs 0 and 3) ----------------
        to_negedge();
        in_valid = 4'b1001;
        for (int j = 0; j < 3; j++) begin
            logic [3:0] exp_g;
            if (j > 0) to_negedge();
            exp_g = (j == 1) ? 4'b0001 : 4'b1000;
            #1;
            check($sformatf("skip ready %0d", j), 64'(in_ready), 64'(exp_g));
            tick();
            check($sformatf("skip grant %0d", j), 64'(grant), 64'(exp_g));
            check($sformatf("skip count %0d", j), 64'(pkt_count), 64'(9 + j));
            $display("skip     accept %0d grant=%b count=%0d", j, grant, pkt_count);
        end

        // ---------------- counter wrap ----------------
        to_negedge();
        in_valid = '0;
        tick();
        check("wrap drain count", 64'(pkt_count), 64'd12);
        to_negedge();
        force dut.pkt_count_reg = 32'hFFFF_FFFE;
        #1;
        release dut.pkt_count_reg;
        in_valid = 4'b0001;
        tick();
        check("wrap preset", 64'(pkt_count), 64'hFFFF_FFFE);
        for (int j = 0; j < 3; j++) begin
            logic [31:0] exp_c;
            exp_c = 32'hFFFF_FFFF + 32'(j);
            if (j == 2) begin
                to_negedge();
                in_valid = '0;
            end
            tick();
            check($sformatf("wrap count %0d", j), 64'(pkt_count), 64'(exp_c));
            $display("wrap     handshake %0d count=%h", j, pkt_count);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
